dpll_corr_sched: RTL and testbench

DPLL_CORR_SCHED -- requirements
Module: dpll_corr_sched

---
 rtl/dpll_pkg.sv | 19 +
 rtl/corr_timer.sv | 30 +++
 rtl/dpll_corr_sched.sv | 174 +++++++++++++++++
 tb/tb_dpll_corr_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// Shared definitions for the DPLL correction scheduler.
//   state_t      : scheduler FSM states
//   PULSE_W_DEF  : default correction pulse width (clk cycles)
//   HOLDOFF_DEF  : default gap after each pulse (clk cycles)
//   TMR_W        : width of the pulse/holdoff down-counter (covers HOLDOFF up to 255)
package dpll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADV  = 2'd1,
        RET  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int PULSE_W_DEF = 4;
    localparam int HOLDOFF_DEF = 8;
    localparam int TMR_W       = 8;

endpackage

// File: rtl/corr_timer.sv
// Pulse/holdoff timer: loads a count, counts down to zero and holds there.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : number of cycles minus one that the phase lasts
//   done       : high while the count is zero (last cycle of the phase)
module corr_timer
    import dpll_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/dpll_corr_sched.sv
// DPLL correction scheduler: turns one-cycle lead/lag requests from the phase
// detector into fixed-width add/deduct pulses for the divider, separated by a
// holdoff gap, with a one-deep pending slot and a saturating net counter.
//   clk, rst_n  : 32 MHz clock, asynchronous active-low reset
//   en          : scheduler enable
//   lead, lag   : one-cycle advance / retard requests
//   clr_stat    : synchronous clear of net_corr and ovr
//   add_pulse   : advance pulse, PULSE_W cycles
//   ded_pulse   : deduct pulse, PULSE_W cycles
//   busy        : high whenever the FSM is not IDLE
//   net_corr    : signed advances minus deducts, saturating
//   ovr         : sticky drop/saturation flag
//   dbg_state   : current FSM state (state_t encoding)
//
// Handshake: lead/lag are fire-and-forget strobes; there is no ready. A
// request is consumed in the cycle it is high; it either starts a pulse,
// is parked in the pending slot, cancels the pending slot, or is dropped.
module dpll_corr_sched
    import dpll_pkg::*;
#(
    parameter int PULSE_W = PULSE_W_DEF,
    parameter int HOLDOFF = HOLDOFF_DEF,
    parameter int CNT_W   = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             lead,
    input  logic             lag,
    input  logic             clr_stat,
    output logic             add_pulse,
    output logic             ded_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] net_corr,
    output logic             ovr,
    output logic [1:0]       dbg_state
);

    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] NET_MAX    = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] NET_MIN    = {1'b1, {(CNT_W-1){1'b0}}};

    state_t           state, state_nxt;
    logic             pend_v, pend_dir, pend_v_nxt, pend_dir_nxt;
    logic             req_v, eff_v, eff_dir, drop;
    logic             start_add, start_ded;
    logic             tmr_load, tmr_done;
    logic [TMR_W-1:0] tmr_val;

    corr_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Merge this cycle's request with the pending slot. Simultaneous lead and
    // lag cancel before reaching here. eff_dir: 1 = advance, 0 = retard.
    always_comb begin
        req_v   = en & (lead ^ lag);
        eff_v   = pend_v;
        eff_dir = pend_dir;
        drop    = 1'b0;
        if (!en) begin
            eff_v = 1'b0;
        end else if (req_v) begin
            if (!pend_v) begin
                eff_v   = 1'b1;
                eff_dir = lead;
            end else if (pend_dir != lead) begin
                eff_v = 1'b0;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        pend_v_nxt   = eff_v;
        pend_dir_nxt = eff_dir;
        start_add    = 1'b0;
        start_ded    = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = PULSE_LOAD;
        case (state)
            IDLE: begin
                pend_v_nxt = 1'b0;
                if (req_v) begin
                    start_add = lead;
                    start_ded = ~lead;
                end
            end
            ADV, RET: begin
                if (tmr_done) begin
                    state_nxt = GAP;
                    tmr_load  = 1'b1;
                    tmr_val   = GAP_LOAD;
                end
            end
            GAP: begin
                // Last gap cycle: the merged request (old pending or a
                // request arriving right now) is served without a detour.
                if (tmr_done) begin
                    pend_v_nxt = 1'b0;
                    if (eff_v) begin
                        start_add = eff_dir;
                        start_ded = ~eff_dir;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (start_add) begin
            state_nxt = ADV;
            tmr_load  = 1'b1;
            tmr_val   = PULSE_LOAD;
        end
        if (start_ded) begin
            state_nxt = RET;
            tmr_load  = 1'b1;
            tmr_val   = PULSE_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend_v    <= 1'b0;
            pend_dir  <= 1'b0;
            add_pulse <= 1'b0;
            ded_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend_v    <= pend_v_nxt;
            pend_dir  <= pend_dir_nxt;
            add_pulse <= (state_nxt == ADV);
            ded_pulse <= (state_nxt == RET);
        end
    end

    // Net counter moves on the edge that starts a pulse; at a limit the
    // pulse still goes out but the count holds and ovr is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            net_corr <= '0;
            ovr      <= 1'b0;
        end else if (clr_stat) begin
            net_corr <= '0;
            ovr      <= 1'b0;
        end else begin
            if (drop) begin
                ovr <= 1'b1;
            end
            if (start_add) begin
                if (net_corr == NET_MAX) ovr <= 1'b1;
                else                     net_corr <= net_corr + 1'b1;
            end
            if (start_ded) begin
                if (net_corr == NET_MIN) ovr <= 1'b1;
                else                     net_corr <= net_corr - 1'b1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_dpll_corr_sched.sv
`timescale 1ns/1ps
module tb_dpll_corr_sched;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       lead = 1'b0;
  logic       lag = 1'b0;
  logic       clr_stat = 1'b0;
  logic       add_pulse, ded_pulse, busy, ovr;
  logic [7:0] net_corr;
  logic [1:0] dbg_state;

  always #15.625 clk = ~clk;

  dpll_corr_sched #(.PULSE_W(4), .HOLDOFF(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .lead      (lead),
    .lag       (lag),
    .clr_stat  (clr_stat),
    .add_pulse (add_pulse),
    .ded_pulse (ded_pulse),
    .busy      (busy),
    .net_corr  (net_corr),
    .ovr       (ovr),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int add_cnt = 0;
  int ded_cnt = 0;
  logic add_prev = 1'b0;
  logic ded_prev = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] add_v, ded_v, busy_v;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse-start monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (add_pulse && !add_prev) add_cnt++;
    if (ded_pulse && !ded_prev) ded_cnt++;
    add_prev = add_pulse;
    ded_prev = ded_pulse;
    if (add_pulse && ded_pulse) begin
      n_checks++;
      n_errors++;
      $display("FAIL both_pulses: got add=1 ded=1 expected never both");
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic first_lead);
    rst_n = 1'b0; lead = 1'b0; lag = 1'b0; en = 1'b1; clr_stat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lead  = first_lead;
    add_cnt = 0;
    ded_cnt = 0;
  endtask

  // Cycle c runs from posedge c to posedge c+1; inputs for cycle c are
  // driven just after posedge c and outputs are sampled at its negedge.
  task automatic run(input logic [63:0] lead_m, input logic [63:0] lag_m, input logic [63:0] en_m);
    for (int c = 0; c < 64; c++) begin
      @(posedge clk);
      #1;
      lead = lead_m[c];
      lag  = lag_m[c];
      en   = en_m[c];
      @(negedge clk);
      add_v[c]  = add_pulse;
      ded_v[c]  = ded_pulse;
      busy_v[c] = busy;
    end
    lead = 1'b0; lag = 1'b0; en = 1'b1;
  endtask

  // Expected: add, ded, busy masks, then {ovr, net_corr} at end of run.
  task automatic scenario(input string name, input logic first_lead,
                          input logic [63:0] lead_m, input logic [63:0] lag_m,
                          input logic [63:0] en_m);
    logic [63:0] e_add, e_ded, e_busy, e_stat;
    do_reset(first_lead);
    run(lead_m, lag_m, en_m);
    e_add  = exp_q.pop_front();
    e_ded  = exp_q.pop_front();
    e_busy = exp_q.pop_front();
    e_stat = exp_q.pop_front();
    check({name, "_add"},  add_v,  e_add);
    check({name, "_ded"},  ded_v,  e_ded);
    check({name, "_busy"}, busy_v, e_busy);
    check({name, "_stat"}, {55'd0, ovr, net_corr}, e_stat);
  endtask

  // One isolated request, then wait until the scheduler is idle again.
  task automatic single_req(input logic dir);
    @(posedge clk); #1;
    lead = dir; lag = ~dir;
    @(posedge clk); #1;
    lead = 1'b0; lag = 1'b0;
    repeat (11) @(posedge clk);
  endtask

  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    // reset values while rst_n is low
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {58'd0, add_pulse, ded_pulse, busy, ovr, dbg_state},
          64'd0);
    check("reset_net", {56'd0, net_corr}, 64'd0);

    // lead at 10: add 11-14, busy 11-22, net 1
    exp_q.push_back(64'h7800); exp_q.push_back(64'h0);
    exp_q.push_back(64'h7F_F800); exp_q.push_back(64'h001);
    scenario("single_lead", 1'b0, 64'h400, 64'h0, ALL);

    // lead 10, lag 12: ded 23-26, net back to 0, no ovr
    exp_q.push_back(64'h7800); exp_q.push_back(64'h780_0000);
    exp_q.push_back(64'h7_FFFF_F800); exp_q.push_back(64'h000);
    scenario("lead_lag", 1'b0, 64'h400, 64'h1000, ALL);

    // lead and lag together: nothing happens
    exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    exp_q.push_back(64'h0); exp_q.push_back(64'h000);
    scenario("cancel_same_cycle", 1'b0, 64'h400, 64'h400, ALL);

    // leads at 10, 12, 13: two pulses, third dropped -> ovr
    exp_q.push_back(64'h780_7800); exp_q.push_back(64'h0);
    exp_q.push_back(64'h7_FFFF_F800); exp_q.push_back(64'h102);
    scenario("drop_same_dir", 1'b0, 64'h3400, 64'h0, ALL);

    // lead presented at reset release: served on first edge
    exp_q.push_back(64'hF); exp_q.push_back(64'h0);
    exp_q.push_back(64'hFFF); exp_q.push_back(64'h001);
    scenario("first_edge", 1'b1, 64'h0, 64'h0, ALL);

    // lead 10, lead 11 pending, en low 12..20: pending cleared, pulse intact
    exp_q.push_back(64'h7800); exp_q.push_back(64'h0);
    exp_q.push_back(64'h7F_F800); exp_q.push_back(64'h001);
    scenario("en_low", 1'b0, 64'hC00, 64'h0, ~64'h1F_F000);

    // lag in the last gap cycle (22): retard served immediately at 23
    exp_q.push_back(64'h7800); exp_q.push_back(64'h780_0000);
    exp_q.push_back(64'h7_FFFF_F800); exp_q.push_back(64'h000);
    scenario("last_gap_req", 1'b0, 64'h400, 64'h40_0000, ALL);

    // lead 10, lag 12 (pending), lead 13 cancels it: one pulse only
    exp_q.push_back(64'h7800); exp_q.push_back(64'h0);
    exp_q.push_back(64'h7F_F800); exp_q.push_back(64'h001);
    scenario("cancel_pending", 1'b0, 64'h2400, 64'h1000, ALL);

    // asynchronous reset in the second cycle of an add pulse
    do_reset(1'b0);
    @(posedge clk); #1; lead = 1'b1;
    @(posedge clk); #1; lead = 1'b0;
    @(posedge clk); #5;
    check("pre_reset_add", {63'd0, add_pulse}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_pulses", {62'd0, add_pulse, ded_pulse}, 64'd0);
    check("async_reset_state", {60'd0, busy, ovr, dbg_state}, 64'd0);
    check("async_reset_net", {56'd0, net_corr}, 64'd0);

    // positive saturation
    do_reset(1'b0);
    for (int i = 0; i < 127; i++) single_req(1'b1);
    @(negedge clk);
    check("sat127_net", {56'd0, net_corr}, 64'h7F);
    check("sat127_ovr", {63'd0, ovr}, 64'd0);
    single_req(1'b1);
    @(negedge clk);
    check("sat128_pulses", 64'(add_cnt), 64'd128);
    check("sat128_net", {56'd0, net_corr}, 64'h7F);
    check("sat128_ovr", {63'd0, ovr}, 64'd1);
    @(posedge clk); #1; clr_stat = 1'b1;
    @(posedge clk); #1; clr_stat = 1'b0;
    @(negedge clk);
    check("clr_stat", {55'd0, ovr, net_corr}, 64'd0);

    // negative saturation
    for (int i = 0; i < 128; i++) single_req(1'b0);
    @(negedge clk);
    check("neg128_net", {56'd0, net_corr}, 64'h80);
    check("neg128_ovr", {63'd0, ovr}, 64'd0);
    single_req(1'b0);
    @(negedge clk);
    check("neg129_pulses", 64'(ded_cnt), 64'd129);
    check("neg129_stat", {55'd0, ovr, net_corr}, 64'h180);

    // clr_stat wins over a pulse starting in the same cycle
    @(posedge clk); #1; clr_stat = 1'b1; lead = 1'b1;
    @(posedge clk); #1; clr_stat = 1'b0; lead = 1'b0;
    @(negedge clk);
    check("clr_priority_stat", {55'd0, ovr, net_corr}, 64'd0);
    check("clr_priority_add", {63'd0, add_pulse}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
